// File: rtl/video_dnn_colorize_stats.sv
// Colorizes a per-pixel digit-classification stream and gathers per-frame
// class histograms, reporting the dominant digit class of each finished frame.
module video_dnn_colorize_stats #(
  parameter int TUSER_WIDTH   = 1,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = 1,
  parameter int NUM_CLASS     = 11,
  parameter int COUNT_WIDTH   = 20
) (
  input  logic                               reset,
  input  logic                               clk,
  input  logic [TCOUNT_WIDTH-1:0]            param_th_count,
  input  logic [NUM_CLASS*24-1:0]            param_palette,
  input  logic [23:0]                        param_background,
  input  logic [TUSER_WIDTH-1:0]             s_axi4s_tuser,
  input  logic                               s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0]           s_axi4s_tnumber,
  input  logic [TCOUNT_WIDTH-1:0]            s_axi4s_tcount,
  input  logic                               s_axi4s_tvalid,
  output logic                               s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]             m_axi4s_tuser,
  output logic                               m_axi4s_tlast,
  output logic [23:0]                        m_axi4s_tdata,
  output logic                               m_axi4s_tvalid,
  input  logic                               m_axi4s_tready,
  output logic [NUM_CLASS*COUNT_WIDTH-1:0]   out_hist,
  output logic [TNUMBER_WIDTH-1:0]           out_max_number,
  output logic [15:0]                        out_frame_count,
  output logic                               out_frame_valid
);

  localparam int IDX_W = $clog2(NUM_CLASS);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic {IDLE, SCAN} state_t;

  // stream register stage
  logic                     r_mValid;
  logic [TUSER_WIDTH-1:0]   r_mUser;
  logic                     r_mLast;
  logic [23:0]              r_mData;

  // statistics state
  logic [COUNT_WIDTH-1:0]   r_accum [NUM_CLASS];
  logic [NUM_CLASS*COUNT_WIDTH-1:0] r_outHist;
  logic                     r_seen;

  // argmax scan state
  state_t                   r_state;
  state_t                   w_nextState;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         r_bestIdx;
  logic [COUNT_WIDTH-1:0]   r_bestCount;
  logic [TNUMBER_WIDTH-1:0] r_maxNumber;
  logic [15:0]              r_frameCount;
  logic [15:0]              r_pendingFrames;
  logic                     r_frameValid;

  logic                     w_accept;
  logic                     w_frameStart;
  logic                     w_snapshot;
  logic                     w_scanDone;
  logic [23:0]              w_color;
  logic [TNUMBER_WIDTH-1:0] w_cls;
  logic [COUNT_WIDTH-1:0]   w_scanCount;

  assign s_axi4s_tready = !r_mValid || m_axi4s_tready;
  assign w_accept       = s_axi4s_tvalid && s_axi4s_tready;
  assign w_frameStart   = w_accept && s_axi4s_tuser[0];
  assign w_snapshot     = w_frameStart && r_seen;

  // Out-of-range class numbers are folded into the "not a digit" bin.
  assign w_cls = (s_axi4s_tnumber >= TNUMBER_WIDTH'(NUM_CLASS - 1)) ?
                 TNUMBER_WIDTH'(NUM_CLASS - 1) : s_axi4s_tnumber;

  // Palette lookup for confident digit pixels, background otherwise.
  always_comb begin
    w_color = param_background;
    for (int k = 0; k < NUM_CLASS - 1; k++) begin
      if (s_axi4s_tnumber == TNUMBER_WIDTH'(k) && s_axi4s_tcount >= param_th_count) begin
        w_color = param_palette[k*24 +: 24];
      end
    end
  end

  // Single output register; holds its beat until the downstream takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mValid <= 1'b0;
      r_mUser  <= '0;
      r_mLast  <= 1'b0;
      r_mData  <= '0;
    end else if (w_accept) begin
      r_mValid <= 1'b1;
      r_mUser  <= s_axi4s_tuser;
      r_mLast  <= s_axi4s_tlast;
      r_mData  <= w_color;
    end else if (m_axi4s_tready) begin
      r_mValid <= 1'b0;
    end
  end

  // Saturating per-class accumulators; a frame start snapshots the previous
  // frame (if one was seen) and restarts counting with the current beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CLASS; k++) r_accum[k] <= '0;
      r_outHist <= '0;
      r_seen    <= 1'b0;
    end else if (w_accept) begin
      if (w_frameStart) begin
        if (r_seen) begin
          for (int k = 0; k < NUM_CLASS; k++) r_outHist[k*COUNT_WIDTH +: COUNT_WIDTH] <= r_accum[k];
        end
        for (int k = 0; k < NUM_CLASS; k++) begin
          r_accum[k] <= (w_cls == TNUMBER_WIDTH'(k)) ? COUNT_WIDTH'(1) : '0;
        end
        r_seen <= 1'b1;
      end else begin
        for (int k = 0; k < NUM_CLASS; k++) begin
          if (w_cls == TNUMBER_WIDTH'(k) && r_accum[k] != COUNT_MAX) begin
            r_accum[k] <= r_accum[k] + COUNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // Next-state logic of the argmax scan; a new snapshot always restarts it.
  always_comb begin
    w_nextState = r_state;
    w_scanDone  = 1'b0;
    w_scanCount = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (r_idx == IDX_W'(k)) w_scanCount = r_outHist[k*COUNT_WIDTH +: COUNT_WIDTH];
    end
    case (r_state)
      IDLE: begin
        if (w_snapshot) w_nextState = SCAN;
      end
      SCAN: begin
        if (w_snapshot) begin
          w_nextState = SCAN;
        end else if (r_idx == IDX_W'(NUM_CLASS - 1)) begin
          w_nextState = IDLE;
          w_scanDone  = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Scan datapath: one class per cycle, strict compare keeps the lowest index
  // on ties; frames snapshotted during an aborted scan are still counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_bestIdx       <= '0;
      r_bestCount     <= '0;
      r_maxNumber     <= '0;
      r_frameCount    <= '0;
      r_pendingFrames <= '0;
      r_frameValid    <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_frameValid <= w_scanDone;
      if (w_snapshot) begin
        r_idx           <= '0;
        r_bestIdx       <= '0;
        r_bestCount     <= '0;
        r_pendingFrames <= r_pendingFrames + 16'd1;
      end else if (w_scanDone) begin
        r_maxNumber     <= TNUMBER_WIDTH'(r_bestIdx);
        r_frameCount    <= r_frameCount + r_pendingFrames;
        r_pendingFrames <= '0;
      end else if (r_state == SCAN) begin
        if (w_scanCount > r_bestCount) begin
          r_bestCount <= w_scanCount;
          r_bestIdx   <= r_idx;
        end
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign m_axi4s_tvalid  = r_mValid;
  assign m_axi4s_tuser   = r_mUser;
  assign m_axi4s_tlast   = r_mLast;
  assign m_axi4s_tdata   = r_mData;
  assign out_hist        = r_outHist;
  assign out_max_number  = r_maxNumber;
  assign out_frame_count = r_frameCount;
  assign out_frame_valid = r_frameValid;

endmodule

// File: tb/tb_video_dnn_colorize_stats.sv
// Directed bench for video_dnn_colorize_stats: colorization, backpressure,
// histogram snapshots, argmax timing, scan restart and reset behaviour.
module tb_video_dnn_colorize_stats;

  localparam int NC = 11;
  localparam int CW = 20;
  localparam int SCW = 3;

  logic            reset;
  logic            clk;
  logic [0:0]      param_th_count;
  logic [NC*24-1:0] param_palette;
  logic [23:0]     param_background;
  logic [0:0]      s_tuser;
  logic            s_tlast;
  logic [3:0]      s_tnumber;
  logic [0:0]      s_tcount;
  logic            s_tvalid;
  logic            s_tready;
  logic [0:0]      m_tuser;
  logic            m_tlast;
  logic [23:0]     m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic [NC*CW-1:0] out_hist;
  logic [3:0]      out_max_number;
  logic [15:0]     out_frame_count;
  logic            out_frame_valid;

  logic            satTready;
  logic [0:0]      satTuser;
  logic            satTlast;
  logic [23:0]     satTdata;
  logic            satTvalid;
  logic [NC*SCW-1:0] satHist;
  logic [3:0]      satMax;
  logic [15:0]     satCount;
  logic            satValid;

  int total = 0;
  int bad = 0;
  int pulseCount = 0;
  logic [23:0] pal [NC];

  video_dnn_colorize_stats dut (
    .reset(reset), .clk(clk),
    .param_th_count(param_th_count), .param_palette(param_palette),
    .param_background(param_background),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tnumber(s_tnumber),
    .s_axi4s_tcount(s_tcount), .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
    .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tdata(m_tdata),
    .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready),
    .out_hist(out_hist), .out_max_number(out_max_number),
    .out_frame_count(out_frame_count), .out_frame_valid(out_frame_valid)
  );

  video_dnn_colorize_stats #(.COUNT_WIDTH(SCW)) satDut (
    .reset(reset), .clk(clk),
    .param_th_count(param_th_count), .param_palette(param_palette),
    .param_background(param_background),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tnumber(s_tnumber),
    .s_axi4s_tcount(s_tcount), .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(satTready),
    .m_axi4s_tuser(satTuser), .m_axi4s_tlast(satTlast), .m_axi4s_tdata(satTdata),
    .m_axi4s_tvalid(satTvalid), .m_axi4s_tready(m_tready),
    .out_hist(satHist), .out_max_number(satMax),
    .out_frame_count(satCount), .out_frame_valid(satValid)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count statistic pulses mid-cycle so each one-cycle pulse counts once
  always @(negedge clk) begin
    if (out_frame_valid === 1'b1) pulseCount++;
  end

  // Hard stop in case something above ever stops advancing
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one observed value against its expected value and tally it
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one beat for one clock (downstream is ready, so it is accepted)
  task automatic applyStimulus(input logic user, input logic last, input int num, input int cnt);
    s_tuser   = user;
    s_tlast   = last;
    s_tnumber = 4'(num);
    s_tcount  = 1'(cnt);
    s_tvalid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic goIdle();
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic doReset();
    goIdle();
    m_tready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Wait (bounded) for the statistics pulse, returning cycles since the call
  task automatic waitPulse(output int cycles);
    cycles = 0;
    while (out_frame_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  function automatic logic [CW-1:0] histOf(input int k);
    return out_hist[k*CW +: CW];
  endfunction

  int cyc, inIdx, outIdx;
  logic inAcc, outAcc;
  int bpNum [4] = '{1, 2, 3, 4};
  logic bpLast [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int statCls [16] = '{7, 7, 7, 7, 2, 2, 7, 7, 7, 7, 2, 2, 2, 10, 10, 7};
  int expHist;

  initial begin
    reset = 1'b1;
    m_tready = 1'b1;
    param_th_count = 1'b1;
    param_background = 24'h000000;
    param_palette = '0;
    for (int k = 0; k < NC; k++) pal[k] = 24'h000000;
    goIdle();
    s_tnumber = '0;
    s_tcount = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_mvalid", m_tvalid, 0);
    checkOutput("rst_mdata", m_tdata, 0);
    checkOutput("rst_hist0", histOf(0), 0);
    checkOutput("rst_maxnum", out_max_number, 0);
    checkOutput("rst_fcount", out_frame_count, 0);
    checkOutput("rst_fvalid", out_frame_valid, 0);
    checkOutput("rst_sready", s_tready, 1);
    reset = 1'b0;

    // Passthrough / colorize
    pal[3] = 24'h00FF00;
    pal[5] = 24'hABCDEF;
    for (int k = 0; k < NC; k++) param_palette[k*24 +: 24] = pal[k];
    applyStimulus(0, 0, 3, 1);
    checkOutput("pt_valid0", m_tvalid, 1);
    checkOutput("pt_data0", m_tdata, 24'h00FF00);
    applyStimulus(0, 0, 3, 0);
    checkOutput("pt_valid1", m_tvalid, 1);
    checkOutput("pt_data1", m_tdata, 24'h000000);
    applyStimulus(0, 1, 10, 1);
    checkOutput("pt_data2", m_tdata, 24'h000000);
    checkOutput("pt_last2", m_tlast, 1);
    param_background = 24'h123456;
    applyStimulus(1, 0, 5, 1);
    checkOutput("pt_data3", m_tdata, 24'hABCDEF);
    checkOutput("pt_user3", m_tuser, 1);
    checkOutput("pt_last3", m_tlast, 0);
    applyStimulus(0, 0, 5, 0);
    checkOutput("pt_below_th", m_tdata, 24'h123456);
    applyStimulus(0, 0, 12, 1);
    checkOutput("pt_big_class", m_tdata, 24'h123456);
    param_th_count = 1'b0;
    applyStimulus(0, 0, 5, 0);
    checkOutput("pt_th_zero", m_tdata, 24'hABCDEF);
    goIdle();
    @(posedge clk);
    #1;
    checkOutput("pt_drain", m_tvalid, 0);
    param_th_count = 1'b1;

    // Backpressure: downstream stalls for 5 cycles during a 4-beat burst
    doReset();
    for (int k = 0; k < NC; k++) begin
      pal[k] = 24'h010101 * (k + 1);
      param_palette[k*24 +: 24] = pal[k];
    end
    inIdx = 0;
    outIdx = 0;
    cyc = 0;
    while (outIdx < 4 && cyc < 40) begin
      m_tready = !(cyc >= 1 && cyc <= 5);
      if (inIdx < 4) begin
        s_tvalid = 1'b1;
        s_tuser = 1'b0;
        s_tcount = 1'b1;
        s_tnumber = 4'(bpNum[inIdx]);
        s_tlast = bpLast[inIdx];
      end else begin
        s_tvalid = 1'b0;
      end
      #1;
      if (cyc == 1) checkOutput("bp_stall_sready", s_tready, 0);
      if (cyc == 3) checkOutput("bp_hold_mvalid", m_tvalid, 1);
      inAcc = s_tvalid && s_tready;
      outAcc = m_tvalid && m_tready;
      if (outAcc) begin
        checkOutput($sformatf("bp_data%0d", outIdx), m_tdata, pal[bpNum[outIdx]]);
        checkOutput($sformatf("bp_last%0d", outIdx), m_tlast, bpLast[outIdx]);
      end
      @(posedge clk);
      #1;
      if (inAcc) inIdx++;
      if (outAcc) outIdx++;
      cyc++;
    end
    checkOutput("bp_beats_out", outIdx, 4);
    goIdle();
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_no_dup", m_tvalid, 0);

    // Statistics: one 8x2 frame then the start of the next
    doReset();
    pulseCount = 0;
    for (int i = 0; i < 16; i++) applyStimulus(i == 0, i == 7 || i == 15, statCls[i], 1);
    applyStimulus(1, 0, 0, 1);
    goIdle();
    for (int k = 0; k < NC; k++) begin
      expHist = (k == 7) ? 9 : (k == 2) ? 5 : (k == 10) ? 2 : 0;
      checkOutput($sformatf("st_hist%0d", k), histOf(k), 64'(expHist));
    end
    checkOutput("st_count_pre", out_frame_count, 0);
    waitPulse(cyc);
    checkOutput("st_latency", cyc, 11);
    checkOutput("st_maxnum", out_max_number, 7);
    checkOutput("st_fcount", out_frame_count, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("st_pulses", pulseCount, 1);
    checkOutput("st_pulse_low", out_frame_valid, 0);

    // Tie between class 4 and class 1 goes to the lower index
    doReset();
    pulseCount = 0;
    for (int i = 0; i < 6; i++) applyStimulus(i == 0, 0, 4, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, i == 5, 1, 1);
    applyStimulus(1, 0, 0, 1);
    goIdle();
    waitPulse(cyc);
    checkOutput("tie_latency", cyc, 11);
    checkOutput("tie_maxnum", out_max_number, 1);
    checkOutput("tie_fcount", out_frame_count, 1);

    // Saturation with a 3-bit counter
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(i == 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    goIdle();
    checkOutput("sat_hist0", satHist[SCW-1:0], 7);
    checkOutput("sat_wide_hist0", histOf(0), 10);

    // Short frames: two snapshots land while a scan is running
    doReset();
    pulseCount = 0;
    for (int i = 0; i < 5; i++) applyStimulus(i == 0, 0, 5, 1);
    for (int i = 0; i < 5; i++) applyStimulus(i == 0, 0, 8, 1);
    for (int i = 0; i < 5; i++) applyStimulus(i == 0, 0, 9, 1);
    applyStimulus(1, 0, 0, 1);
    goIdle();
    checkOutput("sf_no_early_pulse", pulseCount, 0);
    checkOutput("sf_count_pre", out_frame_count, 0);
    checkOutput("sf_hist9", histOf(9), 5);
    waitPulse(cyc);
    checkOutput("sf_latency", cyc, 11);
    checkOutput("sf_maxnum", out_max_number, 9);
    checkOutput("sf_fcount", out_frame_count, 3);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sf_pulses", pulseCount, 1);

    // Reset mid-frame and mid-scan
    doReset();
    pulseCount = 0;
    for (int i = 0; i < 4; i++) applyStimulus(i == 0, 0, 2, 1);
    for (int i = 0; i < 3; i++) applyStimulus(i == 0, 0, 2, 1);
    goIdle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rs_mvalid", m_tvalid, 0);
    checkOutput("rs_hist2", histOf(2), 0);
    checkOutput("rs_fcount", out_frame_count, 0);
    checkOutput("rs_fvalid", out_frame_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rs_sready", s_tready, 1);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("rs_no_stale_pulse", pulseCount, 0);
    for (int i = 0; i < 4; i++) applyStimulus(i == 0, i == 3, 3, 1);
    applyStimulus(1, 0, 0, 1);
    goIdle();
    checkOutput("rs_count_at_snap", out_frame_count, 0);
    checkOutput("rs_no_pulse_yet", pulseCount, 0);
    waitPulse(cyc);
    checkOutput("rs_latency", cyc, 11);
    checkOutput("rs_fcount_after", out_frame_count, 1);
    checkOutput("rs_maxnum", out_max_number, 3);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rs_pulses", pulseCount, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
